// File: rtl/fetch_unit.sv
// Instruction fetch unit: assembles a 32-bit little-endian word from four byte
// reads, holds it until the consumer accepts it, and supports PC redirects.
module fetch_unit #(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        redirect,
    input  logic [7:0]  redirect_pc,
    output logic        mem_req,
    output logic [7:0]  mem_addr,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [7:0]  pc
);

    typedef enum logic [1:0] {
        ST_WAIT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [1:0]  cnt_reg, cnt_next;
    logic [7:0]  pc_reg, pc_next;
    logic        valid_reg, valid_next;
    logic [31:0] instr_reg;
    logic [3:0]  byte_we;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= ST_WAIT;
            cnt_reg   <= 2'd0;
            pc_reg    <= RESET_PC;
            valid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            pc_reg    <= pc_next;
            valid_reg <= valid_next;
        end
    end

    // Redirect outranks both a returning byte and a consumer handshake.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        pc_next    = pc_reg;
        valid_next = valid_reg;
        byte_we    = 4'b0000;
        mem_req    = 1'b0;
        case (state_reg)
            ST_WAIT: begin
                state_next = ST_FETCH;
                cnt_next   = 2'd0;
            end
            ST_FETCH: begin
                mem_req = 1'b1;
                if (redirect) begin
                    pc_next    = redirect_pc;
                    cnt_next   = 2'd0;
                    valid_next = 1'b0;
                end else if (mem_ack) begin
                    byte_we[cnt_reg] = 1'b1;
                    cnt_next         = cnt_reg + 2'd1;
                    if (cnt_reg == 2'd3) begin
                        pc_next    = pc_reg + 8'd4;
                        valid_next = 1'b1;
                        state_next = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (redirect) begin
                    pc_next    = redirect_pc;
                    cnt_next   = 2'd0;
                    valid_next = 1'b0;
                    state_next = ST_FETCH;
                end else if (instr_ready) begin
                    valid_next = 1'b0;
                    state_next = ST_FETCH;
                end
            end
            default: begin
                state_next = ST_WAIT;
                cnt_next   = 2'd0;
                valid_next = 1'b0;
            end
        endcase
    end

    // One register per byte lane; lanes not yet written keep their old bytes.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    instr_reg[8*gi +: 8] <= 8'h00;
                end else if (byte_we[gi]) begin
                    instr_reg[8*gi +: 8] <= mem_rdata;
                end
            end
        end
    endgenerate

    assign mem_addr    = pc_reg + {6'b000000, cnt_reg};
    assign instr       = instr_reg;
    assign instr_valid = valid_reg;
    assign pc          = pc_reg;

endmodule
